reg_wb_sequencer: RTL and testbench
===================================

# reg_wb_sequencer

Write-back sequencer for the general-purpose register file. It accepts register write requests (destination index plus 32-bit result) from the datapath over a valid/ready handshake and buffers them in a small FIFO. It then drains one write per permitted cycle as a one-hot register-enable vector plus data, which is the write-side counterpart of the gated register read path. A combinational hazard query lets the read-side control stall while a write to a given register is still pending.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-low
- wb_valid  in  1  write request present
- wb_ready  out  1  sequencer can accept a request this cycle
- wb_rd  in  4  destination register index
- wb_data  in  32  value to write
- drain_en  in  1  register file write slot available this cycle
- flush  in  1  synchronous discard of all queued writes
- rin  out  16  one-hot register write enable, registered
- d_out  out  32  data for the enabled register, registered
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- rd_query  in  4  register index being read
- hazard  out  1  a write to rd_query is queued or on rin this cycle

## Operation
- State FSM with three states:
  - IDLE: count==0.
  - WRITE: count>0 and drain_en.
  - HOLD: count>0 and !drain_en.
  - Next state is derived from count and drain_en after each edge.
  - flush forces IDLE.
- Push: at rising edge when wb_valid && wb_ready. Entry {wb_rd, wb_data} is written at the tail. Tail pointer wraps modulo DEPTH.
- wb_ready = (count < DEPTH) && !flush. There is no accept-while-full, even if a pop occurs in the same cycle.
- Pop: at rising edge when count>0 && drain_en && !flush.
  - rin <= 1 << head.rd.
  - d_out <= head.data.
  - Head pointer advances modulo DEPTH.
- Edges without a pop: rin <= 0; d_out holds its previous value.
- Simultaneous push and pop: both happen, and count is unchanged. An entry pushed into an empty FIFO is not popped in the same edge.
- flush has priority over push and pop. It sets count <= 0, equalises the pointers, and sets rin <= 0. d_out holds.
- hazard is combinational. It is 1 if any of the count valid entries has rd==rd_query, or if rin[rd_query]==1.
- Order: writes reach rin strictly in acceptance order. Two writes to the same register both appear, oldest first.

## Timing
- Reset (clr low, asynchronous): rin=0, d_out=0, count=0, pointers=0, state IDLE. Consequently wb_ready=1 and hazard=0.
- Reset mid-operation discards all queued entries immediately and clears any asserted rin bit without waiting for a clock edge.
- Latency: a request accepted at edge N appears on rin/d_out after edge N+1 at the earliest (when drain_en is high at N+1). rin is high for exactly one cycle per write.
- Throughput: one push and one pop per cycle sustained.
- wb_ready deasserts in the cycle after the edge that makes count==DEPTH.
- count never exceeds DEPTH and never underflows. drain_en with count==0 produces no rin pulse.

## Configuration
- R0_WRITE_PROTECT_EN
  - Defined: a handshake with wb_rd==0 completes (wb_ready behaves normally) but the entry is not enqueued and count does not change. rin[0] is never asserted, and hazard for rd_query==0 is always 0.
  - Undefined: R0 is treated like every other register.

## Test plan
- Reset, then push {rd=5, data=0x0000_00AA} with drain_en=1 -> rin=0x0020 and d_out=0x0000_00AA for one cycle, two edges after the push; count returns to 0.
- drain_en=0, push rd=1,2,3,4 with DEPTH=4 -> count=4, wb_ready=0, and a fifth request is not accepted. Then drain_en=1 -> rin sequence 0x0002, 0x0004, 0x0008, 0x0010 on consecutive cycles.
- count=2, push and drain in the same cycle -> count stays 2; output order is preserved across pointer wrap after 10 mixed push/pop cycles.
- Queue rd=7 with drain_en=0, set rd_query=7 -> hazard=1. Set rd_query=6 -> hazard=0. After the rd=7 pulse on rin has completed -> hazard=0.
- Three entries queued, assert flush together with wb_valid -> count=0, no rin pulse, and the request is not accepted. Drop clr mid-drain -> rin=0 and d_out=0 immediately.
- Push rd=0 with data 0x1234_5678:
  - Macro defined: count stays 0 and rin[0] is never asserted.
  - Macro undefined: rin=0x0001 and d_out=0x1234_5678.

Source files
------------

// File: rtl/reg_wb_sequencer.sv
// Register write-back sequencer: FIFO of {rd, data} drained as a one-hot enable plus data.
// Optional macro R0_WRITE_PROTECT_EN: writes to register 0 are accepted but dropped.
module reg_wb_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [3:0]               wb_rd,
    input  logic [31:0]              wb_data,
    input  logic                     drain_en,
    input  logic                     flush,
    output logic [15:0]              rin,
    output logic [31:0]              d_out,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [3:0]               rd_query,
    output logic                     hazard
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [CW-1:0]     count_next;
    state_t            state;
    logic              push;
    logic              enq;
    logic              pop;

    assign wb_ready = (count < CW'(DEPTH)) && !flush;
    assign push     = wb_valid && wb_ready;
    assign pop      = (count != '0) && drain_en && !flush;

`ifdef R0_WRITE_PROTECT_EN
    assign enq = push && (wb_rd != 4'd0);
`else
    assign enq = push;
`endif

    always_comb begin
        count_next = count;
        case ({enq, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy, drain outputs and the occupancy-tracking state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rin   <= '0;
            d_out <= '0;
            state <= IDLE;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rin   <= '0;
            state <= IDLE;
        end else begin
            if (enq) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head  <= head + AW'(1);
                rin   <= 16'(1) << mem[head].rd;
                d_out <= mem[head].data;
            end else begin
                rin <= '0;
            end
            count <= count_next;
            if (count_next == '0) begin
                state <= IDLE;
            end else if (drain_en) begin
                state <= WRITE;
            end else begin
                state <= HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= '{rd: wb_rd, data: wb_data};
        end
    end

    // Pending-write lookup over the valid window starting at head.
    always_comb begin
        hazard = rin[rd_query];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (mem[head + AW'(i)].rd == rd_query)) begin
                hazard = 1'b1;
            end
        end
    end

    a_idle_iff_empty: assert property (@(posedge clk) disable iff (!clr)
        ((state == IDLE) == (count == '0)));

endmodule

// File: tb/tb_reg_wb_sequencer.sv
// Self-checking bench for reg_wb_sequencer against a queue-based reference model.
module tb_reg_wb_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef R0_WRITE_PROTECT_EN
    localparam bit R0P = 1'b1;
`else
    localparam bit R0P = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [3:0]    wb_rd = '0;
    logic [31:0]   wb_data = '0;
    logic          drain_en = 1'b0;
    logic          flush = 1'b0;
    logic [15:0]   rin;
    logic [31:0]   d_out;
    logic [CW-1:0] count;
    logic [3:0]    rd_query = '0;
    logic          hazard;

    int vectors = 0;
    int miscompares = 0;

    bit [35:0] mq[$];
    bit [15:0] m_rin = '0;
    bit [31:0] m_dout = '0;

    reg_wb_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .drain_en(drain_en), .flush(flush),
        .rin(rin), .d_out(d_out), .count(count), .rd_query(rd_query), .hazard(hazard)
    );

    always #5 clk = ~clk;

    function automatic bit model_hazard(input bit [3:0] q);
        bit h;
        h = m_rin[q];
        foreach (mq[i]) if (mq[i][35:32] == q) h = 1'b1;
        return h;
    endfunction

    // Advance the reference model by one edge using the current inputs, then clock the DUT.
    task automatic cycle();
        bit rdy;
        bit [35:0] e;
        rdy = (mq.size() < DEPTH) && !flush;
        if (flush) begin
            mq.delete();
            m_rin = '0;
        end else begin
            if (mq.size() > 0 && drain_en) begin
                e = mq.pop_front();
                m_rin = 16'(1) << e[35:32];
                m_dout = e[31:0];
            end else begin
                m_rin = '0;
            end
            if (wb_valid && rdy && !(R0P && wb_rd == 4'd0)) mq.push_back({wb_rd, wb_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; drain_en = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (rin !== 16'h0) begin miscompares++; $display("FAIL reset_rin got %h want 0000", rin); end
        vectors++; if (d_out !== 32'h0) begin miscompares++; $display("FAIL reset_dout got %h want 0", d_out); end
        vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (wb_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", wb_ready); end
        vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL reset_hazard got %b want 0", hazard); end
        clr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        wb_valid = 1'b1; wb_rd = 4'd5; wb_data = 32'hAA; drain_en = 1'b1;
        cycle();
        wb_valid = 1'b0;
        vectors++; if (rin !== 16'h0 || count !== CW'(1)) begin miscompares++; $display("FAIL single_edge1 got rin=%h count=%0d want 0000/1", rin, count); end
        cycle();
        vectors++; if (rin !== 16'h0020 || d_out !== 32'hAA) begin miscompares++; $display("FAIL single_pulse got %h/%h want 0020/000000aa", rin, d_out); end
        vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL single_count got %0d want 0", count); end
        cycle();
        vectors++; if (rin !== 16'h0 || d_out !== 32'hAA) begin miscompares++; $display("FAIL single_after got %h/%h want 0000/000000aa", rin, d_out); end
        idle_inputs();
    endtask

    task automatic test_full();
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1'b1; wb_rd = 4'(i); wb_data = 32'(i * 16);
            cycle();
        end
        vectors++; if (count !== CW'(4) || wb_ready !== 1'b0) begin miscompares++; $display("FAIL full_state got count=%0d ready=%b want 4/0", count, wb_ready); end
        wb_rd = 4'd9; wb_data = 32'h99;
        cycle();
        vectors++; if (count !== CW'(4)) begin miscompares++; $display("FAIL full_reject got %0d want 4", count); end
        drain_en = 1'b1;
        #1;
        vectors++; if (wb_ready !== 1'b0) begin miscompares++; $display("FAIL full_pop_ready got %b want 0", wb_ready); end
        for (int i = 1; i <= 4; i++) begin
            cycle();
            wb_valid = 1'b0;
            vectors++; if (rin !== 16'(1) << i || d_out !== 32'(i * 16)) begin miscompares++; $display("FAIL full_drain%0d got %h/%h want %h", i, rin, d_out, 16'(1) << i); end
        end
        cycle();
        vectors++; if (rin !== 16'h0 || count !== CW'(0)) begin miscompares++; $display("FAIL full_empty got rin=%h count=%0d want 0000/0", rin, count); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        wb_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wb_rd = 4'(10 + i); wb_data = $urandom;
            cycle();
        end
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wb_rd = 4'($urandom); wb_data = $urandom;
            cycle();
            vectors++; if (count !== CW'(2)) begin miscompares++; $display("FAIL b2b_count%0d got %0d want 2", i, count); end
            vectors++; if (rin !== m_rin || d_out !== m_dout) begin miscompares++; $display("FAIL b2b_order%0d got %h/%h want %h/%h", i, rin, d_out, m_rin, m_dout); end
        end
        wb_valid = 1'b0;
        cycle(); cycle(); cycle();
        vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL b2b_drained got %0d want 0", count); end
        idle_inputs();
    endtask

    task automatic test_hazard();
        wb_valid = 1'b1; wb_rd = 4'd7; wb_data = 32'h77;
        cycle();
        wb_valid = 1'b0; rd_query = 4'd7;
        #1;
        vectors++; if (hazard !== 1'b1) begin miscompares++; $display("FAIL hazard_queued got %b want 1", hazard); end
        rd_query = 4'd6;
        #1;
        vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL hazard_other got %b want 0", hazard); end
        rd_query = 4'd7; drain_en = 1'b1;
        cycle();
        vectors++; if (hazard !== 1'b1 || rin !== 16'h0080) begin miscompares++; $display("FAIL hazard_on_rin got %b/%h want 1/0080", hazard, rin); end
        cycle();
        vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL hazard_done got %b want 0", hazard); end
        idle_inputs();
    endtask

    task automatic test_flush_and_reset();
        wb_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_rd = 4'(2 + i); wb_data = 32'(100 + i);
            cycle();
        end
        flush = 1'b1; wb_rd = 4'd12;
        #1;
        vectors++; if (wb_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready got %b want 0", wb_ready); end
        cycle();
        vectors++; if (count !== CW'(0) || rin !== 16'h0) begin miscompares++; $display("FAIL flush_state got count=%0d rin=%h want 0/0000", count, rin); end
        flush = 1'b0; wb_valid = 1'b0; drain_en = 1'b1;
        cycle();
        vectors++; if (rin !== 16'h0) begin miscompares++; $display("FAIL flush_nopulse got %h want 0000", rin); end
        drain_en = 1'b0; wb_valid = 1'b1;
        wb_rd = 4'd3; wb_data = 32'hC3; cycle();
        wb_rd = 4'd4; wb_data = 32'hC4; cycle();
        wb_valid = 1'b0; drain_en = 1'b1;
        cycle();
        vectors++; if (rin !== 16'h0008) begin miscompares++; $display("FAIL middrain_pulse got %h want 0008", rin); end
        clr = 1'b0;
        #1;
        vectors++; if (rin !== 16'h0 || d_out !== 32'h0 || count !== CW'(0)) begin miscompares++; $display("FAIL async_reset got %h/%h/%0d want 0000/0/0", rin, d_out, count); end
        mq.delete(); m_rin = '0; m_dout = '0;
        idle_inputs();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_r0();
        wb_valid = 1'b1; wb_rd = 4'd0; wb_data = 32'h1234_5678; drain_en = 1'b1;
        cycle();
        wb_valid = 1'b0;
        vectors++; if (count !== CW'(R0P ? 0 : 1)) begin miscompares++; $display("FAIL r0_count got %0d want %0d", count, R0P ? 0 : 1); end
        cycle();
        if (R0P) begin
            vectors++; if (rin !== 16'h0) begin miscompares++; $display("FAIL r0_protect got %h want 0000", rin); end
        end else begin
            vectors++; if (rin !== 16'h0001 || d_out !== 32'h1234_5678) begin miscompares++; $display("FAIL r0_write got %h/%h want 0001/12345678", rin, d_out); end
        end
        cycle();
        idle_inputs();
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int n = 0; n < 400; n++) begin
            wb_valid = $urandom_range(0, 3) != 0;
            wb_rd    = 4'($urandom);
            wb_data  = $urandom;
            drain_en = ((n % 100) < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush    = $urandom_range(0, 29) == 0;
            rd_query = 4'($urandom);
            #1;
            exp_rdy = (mq.size() < DEPTH) && !flush;
            vectors++; if (wb_ready !== exp_rdy) begin miscompares++; $display("FAIL rnd_ready%0d got %b want %b", n, wb_ready, exp_rdy); end
            vectors++; if (hazard !== model_hazard(rd_query)) begin miscompares++; $display("FAIL rnd_hazard%0d got %b want %b", n, hazard, model_hazard(rd_query)); end
            cycle();
            vectors++; if (rin !== m_rin || d_out !== m_dout) begin miscompares++; $display("FAIL rnd_out%0d got %h/%h want %h/%h", n, rin, d_out, m_rin, m_dout); end
            vectors++; if (count !== CW'(mq.size())) begin miscompares++; $display("FAIL rnd_count%0d got %0d want %0d", n, count, mq.size()); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_hazard();
        test_flush_and_reset();
        test_r0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
